// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Multi-digit 7-segment scan controller for the stopwatch front panel.
//   One digit position is enabled at a time and held for SCAN_DIV cycles.
//   For the enabled digit the segment pattern is chosen from, highest
//   priority first:
//     time view (mode=1):      blinking over-start error, else the BCD time value
//     stopwatch view (mode=0): blinking over-start error, blinking changing
//                              error, spinner, else the BCD stopwatch value
//   Leading zeros are blanked in the value displays when LZ_BLANK=1.
//   Digit 0 is never blanked.
//
// Ports
//   clk                    clock
//   reset                  synchronous, active-low reset
//   digits_run             stopwatch value, BCD, digit k at [4k+3:4k]
//   digits_time            time value, same packing
//   mode                   0 = stopwatch view, 1 = time view
//   signal                 show the spinner instead of the stopwatch value
//   error_over_start       over-start error, stopwatch view
//   error_over_start_time  over-start error, time view
//   error_changing         changing error, stopwatch view
//   seg_out                registered segments, active-high, bit0=a .. bit6=g
//   dig_en                 registered one-hot digit enable, active-high
//
// All outputs are registered. Each cycle they take the pattern for the
// current idx and current inputs, so any input change or idx step shows
// up one cycle later.

module display_scan_ctrl #(
  parameter int         NUM_DIGITS   = 4,
  parameter int         SCAN_DIV     = 1000,
  parameter int         SPIN_DIV     = 5000000,
  parameter int         BLINK_DIV    = 25000000,
  parameter bit         LZ_BLANK     = 1'b1,
  parameter logic [6:0] ERR_OVER_PAT = 7'd119,
  parameter logic [6:0] ERR_CHG_PAT  = 7'd3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_run,
  input  logic [4*NUM_DIGITS-1:0] digits_time,
  input  logic                    mode,
  input  logic                    signal,
  input  logic                    error_over_start,
  input  logic                    error_over_start_time,
  input  logic                    error_changing,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int SPIN_W  = (SPIN_DIV   > 1) ? $clog2(SPIN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(SPIN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]         PHASE_LAST = 3'd6;

  logic [SCAN_W-1:0]     scan_div;
  logic [IDX_W-1:0]      idx;
  logic [SPIN_W-1:0]     spin_cnt;
  logic [2:0]            phase;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_on;

  logic                  err_act;
  logic [3:0]            cur_run;
  logic [3:0]            cur_time;
  logic                  run_upper_zero;
  logic                  time_upper_zero;
  logic                  run_blank;
  logic                  time_blank;
  logic [6:0]            spin_pat;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_en_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // The blink timer runs only while the error that is actually visible in
  // the current view is asserted.
  assign err_act = mode ? error_over_start_time
                        : (error_over_start | error_changing);

  always_comb begin
    cur_run         = 4'd0;
    cur_time        = 4'd0;
    run_upper_zero  = 1'b1;
    time_upper_zero = 1'b1;
    dig_en_next     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx) begin
        cur_run        = digits_run[4*k +: 4];
        cur_time       = digits_time[4*k +: 4];
        dig_en_next[k] = 1'b1;
      end
      // A digit is a leading zero when it and every digit above it are 0.
      if (k >= int'(idx)) begin
        if (digits_run[4*k +: 4] != 4'd0)  run_upper_zero  = 1'b0;
        if (digits_time[4*k +: 4] != 4'd0) time_upper_zero = 1'b0;
      end
    end

    run_blank  = LZ_BLANK && (idx != '0) && run_upper_zero;
    time_blank = LZ_BLANK && (idx != '0) && time_upper_zero;
    spin_pat   = 7'b000_0001 << phase;

    seg_next = 7'h00;
    if (mode) begin
      if (error_over_start_time) seg_next = blink_on ? ERR_OVER_PAT : 7'h00;
      else if (!time_blank)      seg_next = bcd_to_seg(cur_time);
    end else begin
      if (error_over_start)      seg_next = blink_on ? ERR_OVER_PAT : 7'h00;
      else if (error_changing)   seg_next = blink_on ? ERR_CHG_PAT : 7'h00;
      else if (signal)           seg_next = spin_pat;
      else if (!run_blank)       seg_next = bcd_to_seg(cur_run);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_div  <= '0;
      idx       <= '0;
      spin_cnt  <= '0;
      phase     <= 3'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      seg_out   <= 7'h00;
      dig_en    <= '0;
    end else begin
      // Digit scan: never stalls, regardless of errors or spinner.
      if (scan_div == SCAN_LAST) begin
        scan_div <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end

      // Spinner held at phase 0 while idle so every run starts at segment a.
      if (!signal) begin
        spin_cnt <= '0;
        phase    <= 3'd0;
      end else if (spin_cnt == SPIN_LAST) begin
        spin_cnt <= '0;
        phase    <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
      end else begin
        spin_cnt <= spin_cnt + 1'b1;
      end

      // Blink held in the "on" half while idle so a new error is visible
      // at once for a full half-period.
      if (!err_act) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      seg_out <= seg_next;
      dig_en  <= dig_en_next;
    end
  end

endmodule
